branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Parametrised, tagged branch target buffer with 2-bit saturating direction counters, for the fetch stage of the pipelined 16-bit core. It replaces the untagged, always-taken predictor table embedded in the CPU top. It adds tag checking, hysteresis on direction, explicit invalidation for self-modifying stores, and a reset-time clearing sweep. Lookup is combinational so fetch can form the next PC in the same cycle. Update and invalidate are registered, driven from writeback.

## Interface
- PC_W, 16: PC/address width in bits; instructions are 2-byte aligned, so PC bit 0 is ignored.
- INDEX_W, 10: index width; DEPTH = 2^INDEX_W entries; index = pc[INDEX_W:1].
- CTR_INIT, 2: counter value on allocation (0..3; 2 = weakly taken).
- Derived, not settable: TAG_W = PC_W-1-INDEX_W; tag = pc[PC_W-1:INDEX_W+1].

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- lookup_pc  in  PC_W  current fetch PC.
- pred_hit  out  1  entry valid and tag matches lookup_pc.
- pred_taken  out  1  pred_hit and counter >= 2.
- pred_pc  out  PC_W  predicted next PC: entry target if pred_taken, else lookup_pc+2.
- ready  out  1  clearing sweep complete; table usable.
- upd_valid  in  1  resolved control-transfer update this cycle.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_taken  in  1  branch resolved taken.
- upd_target  in  PC_W  resolved target (meaningful when upd_taken).
- inv_valid  in  1  invalidate request (store to code space).
- inv_addr  in  PC_W  store address; selects entry by index.

## Operation
- Entry = {valid, tag[TAG_W], target[PC_W], ctr[2]}. Storage is a register array of DEPTH entries.
- Lookup is purely combinational from lookup_pc and current table state. When ready=0: pred_hit=0, pred_taken=0, pred_pc=lookup_pc+2.
- lookup_pc+2 wraps modulo 2^PC_W (0xFFFE+2 = 0x0000 for PC_W=16).
- States: SWEEP and RUN.
- SWEEP:
  - While reset=1: sweep_idx<=0, ready<=0, state<=SWEEP.
  - Each cycle with reset=0: clear valid of entry sweep_idx, then sweep_idx+1.
  - At sweep_idx==DEPTH-1: ready<=1, state<=RUN.
  - upd/inv inputs are ignored in SWEEP.
- RUN, update when upd_valid=1. "Hit" means the entry at index(upd_pc) is valid and its tag equals tag(upd_pc).
  - Taken & hit: target<=upd_target; ctr<=min(ctr+1,3).
  - Taken & miss: allocate (overwrites any alias): valid<=1, tag<=tag(upd_pc), target<=upd_target, ctr<=CTR_INIT.
  - Not taken & hit: ctr<=max(ctr-1,0); entry stays valid.
  - Not taken & miss: no change.
- RUN, invalidate when inv_valid=1: valid<=0 at index(inv_addr), regardless of tag.
- Simultaneous upd and inv on the same index: invalidate wins; the entry ends up invalid. Different indices: both take effect.
- reset=1 mid-sweep or in RUN: restart the sweep from index 0; ready drops on the next edge.

## Timing
- Reset values, after the edge that samples reset=1: ready=0; pred_hit=0; pred_taken=0; pred_pc=lookup_pc+2.
- ready rises on the DEPTH-th rising edge after reset is first sampled 0 (1024 edges at the default).
- Lookup latency 0 cycles (combinational).
- Update/invalidate visible to lookup on the cycle after the edge that samples them.
- A lookup in the same cycle as an update to that entry sees the pre-update state.
- No backpressure; upd/inv are single-cycle pulses and are always accepted in RUN.

## Test plan
- Reset then idle: ready=0 for 1023 edges and 1 from edge 1024; lookup 0x0010 -> pred_hit=0, pred_pc=0x0012 throughout.
- Allocate: upd_pc=0x0010, taken, target=0x0040 -> next cycle lookup 0x0010: pred_hit=1, pred_taken=1, pred_pc=0x0040.
- Hysteresis: after that allocation (ctr=2), one not-taken update -> ctr=1, lookup gives pred_hit=1, pred_taken=0, pred_pc=0x0012. Two taken updates -> ctr=3. Then one not-taken -> still predicts 0x0040.
- Aliasing: with 0x0010 allocated, lookup 0x0810 (same index 8, tag 1) -> pred_hit=0, pred_pc=0x0812. Taken update at 0x0810 -> entry replaced, and lookup 0x0010 now misses.
- Invalidate collision: same-cycle taken update at 0x0010 and inv_addr=0x0010 -> entry invalid, and lookup 0x0010 -> pred_pc=0x0012. Invalidate at 0x0020 leaves 0x0010 intact.
- Reset mid-operation: assert reset for 1 cycle with entries valid, then release -> ready=0 until 1024 edges later, and all prior entries miss afterwards. Also wrap case: allocate at 0xFFFE, not-taken update, lookup 0xFFFE -> pred_pc=0x0000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer with 2-bit saturating direction counters.
// The lookup is combinational. Update and invalidate are registered, and a sweep clears valid bits after reset.
module branch_target_buffer #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned CTR_INIT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    output logic            ready,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            inv_valid,
    input  logic [PC_W-1:0] inv_addr
);

    localparam int unsigned DEPTH = 2 ** INDEX_W;
    localparam int unsigned TAG_W = PC_W - 1 - INDEX_W;
    localparam logic [1:0]  CtrInit = CTR_INIT[1:0];

    typedef enum logic [0:0] {StSweep, StRun} state_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   sweep_idx_q, sweep_idx_d;

    logic                 valid_q  [DEPTH];
    logic [TAG_W-1:0]     tag_q    [DEPTH];
    logic [PC_W-1:0]      target_q [DEPTH];
    logic [1:0]           ctr_q    [DEPTH];

    logic [INDEX_W-1:0]   lk_idx, upd_idx, inv_idx;
    logic [TAG_W-1:0]     lk_tag, upd_tag;
    logic                 upd_hit;
    logic [1:0]           upd_ctr;

    // PC bit 0 is meaningless, and invalidation selects by index only
    logic unused_bits;
    assign unused_bits = ^{upd_pc[0], inv_addr[0], inv_addr[PC_W-1:INDEX_W+1]};

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        unique case (state_q)
            StSweep: begin
                sweep_idx_d = sweep_idx_q + INDEX_W'(1);
                if (&sweep_idx_q) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StSweep;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSweep;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    assign ready = (state_q == StRun);

    assign lk_idx  = lookup_pc[INDEX_W:1];
    assign lk_tag  = lookup_pc[PC_W-1:INDEX_W+1];
    assign upd_idx = upd_pc[INDEX_W:1];
    assign upd_tag = upd_pc[PC_W-1:INDEX_W+1];
    assign inv_idx = inv_addr[INDEX_W:1];

    always_comb begin
        pred_hit   = ready && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = pred_hit && ctr_q[lk_idx][1];
        pred_pc    = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(2);
    end

    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctr = ctr_q[upd_idx];
        if (upd_taken) begin
            if (!upd_hit)                   upd_ctr = CtrInit;
            else if (upd_ctr != 2'b11)      upd_ctr = upd_ctr + 2'd1;
        end else if (upd_ctr != 2'b00) begin
            upd_ctr = upd_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StSweep) begin
                valid_q[sweep_idx_q] <= 1'b0;
            end else begin
                if (upd_valid && (upd_taken || upd_hit)) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    ctr_q[upd_idx]    <= upd_ctr;
                    if (upd_taken) target_q[upd_idx] <= upd_target;
                end
                // Later assignment makes invalidate win on an index collision
                if (inv_valid) valid_q[inv_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal expectations plus a random phase.
// A per-cycle compare process checks the DUT against a behavioural table model.
module tb_branch_target_buffer;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INDEX_W = 10;
    localparam int unsigned DEPTH   = 1 << INDEX_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] lookup_pc = 16'h0010;
    logic            pred_hit, pred_taken, ready;
    logic [PC_W-1:0] pred_pc;
    logic            upd_valid = 1'b0, upd_taken = 1'b0, inv_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0, upd_target = '0, inv_addr = '0;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    branch_target_buffer #(.PC_W(PC_W), .INDEX_W(INDEX_W), .CTR_INIT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (lookup_pc),
        .pred_hit  (pred_hit),
        .pred_taken(pred_taken),
        .pred_pc   (pred_pc),
        .ready     (ready),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .upd_target(upd_target),
        .inv_valid (inv_valid),
        .inv_addr  (inv_addr)
    );

    always #5 clk = ~clk;

    // Behavioural model: table of entries plus edge count since reset release
    bit          m_ready = 1'b0;
    int unsigned m_cnt = 0;
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    int unsigned m_tgt   [DEPTH];
    int unsigned m_ctr   [DEPTH];

    function automatic int unsigned idx_of(int unsigned pc);
        return (pc >> 1) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(int unsigned pc);
        return pc >> (INDEX_W + 1);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end
        end else begin
            if (upd_valid) begin
                int unsigned i;
                bit hit;
                i   = idx_of(upd_pc);
                hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
                if (upd_taken) begin
                    m_tgt[i] = upd_target;
                    if (hit) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    end else begin
                        m_valid[i] = 1'b1;
                        m_tag[i]   = tag_of(upd_pc);
                        m_ctr[i]   = 2;
                    end
                end else if (hit) begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end
            if (inv_valid) m_valid[idx_of(inv_addr)] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            int unsigned i;
            bit e_hit, e_taken;
            int unsigned e_pc;
            i       = idx_of(lookup_pc);
            e_hit   = m_ready && m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
            e_taken = e_hit && (m_ctr[i] >= 2);
            e_pc    = e_taken ? m_tgt[i] : (lookup_pc + 2) % (1 << PC_W);
            check("cyc_ready", 32'(ready), 32'(m_ready));
            check("cyc_hit", 32'(pred_hit), 32'(e_hit));
            check("cyc_taken", 32'(pred_taken), 32'(e_taken));
            check("cyc_pc", 32'(pred_pc), e_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string name, input logic [15:0] pc, input logic e_hit,
                        input logic e_taken, input logic [15:0] e_pc);
        lookup_pc = pc;
        #1;
        check({name, "_hit"}, 32'(pred_hit), 32'(e_hit));
        check({name, "_taken"}, 32'(pred_taken), 32'(e_taken));
        check({name, "_pc"}, 32'(pred_pc), 32'(e_pc));
    endtask

    task automatic sweep_and_check(input string name);
        for (int k = 0; k < DEPTH - 1; k++) tick();
        check({name, "_ready_1023"}, 32'(ready), 32'd0);
        tick();
        check({name, "_ready_1024"}, 32'(ready), 32'd1);
    endtask

    initial begin
        tick();
        cmp_on = 1'b1;
        tick();
        look("rst", 16'h0010, 1'b0, 1'b0, 16'h0012);
        check("rst_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        sweep_and_check("init");
        look("idle", 16'h0010, 1'b0, 1'b0, 16'h0012);

        upd(16'h0010, 1'b1, 16'h0040);
        look("alloc", 16'h0010, 1'b1, 1'b1, 16'h0040);
        upd(16'h0010, 1'b0, 16'h0000);
        look("hyst_nt", 16'h0010, 1'b1, 1'b0, 16'h0012);
        upd(16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 1'b0, 16'h0000);
        look("hyst_sat", 16'h0010, 1'b1, 1'b1, 16'h0040);

        look("alias_miss", 16'h0810, 1'b0, 1'b0, 16'h0812);
        upd(16'h0810, 1'b1, 16'h0100);
        look("alias_new", 16'h0810, 1'b1, 1'b1, 16'h0100);
        look("alias_old", 16'h0010, 1'b0, 1'b0, 16'h0012);

        upd(16'h0010, 1'b1, 16'h0040);
        inv_valid = 1'b1; inv_addr = 16'h0010;
        upd(16'h0010, 1'b1, 16'h0050);
        inv_valid = 1'b0;
        look("inv_coll", 16'h0010, 1'b0, 1'b0, 16'h0012);
        upd(16'h0010, 1'b1, 16'h0040);
        inv_valid = 1'b1; inv_addr = 16'h0020;
        tick();
        inv_valid = 1'b0;
        look("inv_other", 16'h0010, 1'b1, 1'b1, 16'h0040);

        upd(16'hFFFE, 1'b1, 16'h1234);
        upd(16'hFFFE, 1'b0, 16'h0000);
        look("wrap", 16'hFFFE, 1'b1, 1'b0, 16'h0000);

        // Random traffic over a few indices and tags to force hits, aliases and collisions
        for (int n = 0; n < 3000; n++) begin
            upd_valid  = ($urandom_range(0, 1) == 1);
            upd_taken  = ($urandom_range(0, 9) < 6);
            upd_pc     = 16'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 1)
                             | $urandom_range(0, 1));
            upd_target = 16'($urandom);
            inv_valid  = ($urandom_range(0, 9) < 2);
            inv_addr   = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 1));
            lookup_pc  = 16'(($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 1)
                             | $urandom_range(0, 1));
            tick();
        end
        upd_valid = 1'b0; inv_valid = 1'b0;

        upd(16'h0010, 1'b1, 16'h0040);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'd0);
        for (int k = 0; k < 500; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_and_check("resweep");
        look("post_rst", 16'h0010, 1'b0, 1'b0, 16'h0012);
        look("post_rst_wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
